// File: rtl/draw_layer_arbiter.sv
// Fixed-priority pixel arbiter for four sprite layers over the background, with
// per-frame collision detection reported as one-cycle pulses after each frame start.
module draw_layer_arbiter #(
  parameter logic [7:0] TRANSPARENT_COLOR = 8'hFF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       collisionEn,
  input  logic [3:0] drawReq,
  input  logic [7:0] missileRGB,
  input  logic [7:0] bombRGB,
  input  logic [7:0] alienRGB,
  input  logic [7:0] playerRGB,
  input  logic [7:0] BG_RGB,
  input  logic       boardersDrawReq,
  output logic [7:0] RGBOut,
  output logic [2:0] layerSel,
  output logic       alienHit,
  output logic       playerHit,
  output logic       alienAtBorder,
  output logic       playerAtBorder
);

  typedef enum logic [1:0] {
    WAIT_SOF,
    COLLECT,
    REPORT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] eff;
  logic [7:0] rgb_d, rgb_q;
  logic [2:0] sel_d, sel_q;
  // Overlap/flag bit order: [0]=alienHit [1]=playerHit [2]=alienAtBorder [3]=playerAtBorder
  logic [3:0] ovl, ovl_g;
  logic [3:0] flags_d, flags_q;
  logic [3:0] snap_d, snap_q;
  logic [3:0] pulse_d, pulse_q;

  always_comb begin
    eff[0] = drawReq[0] && (missileRGB != TRANSPARENT_COLOR);
    eff[1] = drawReq[1] && (bombRGB    != TRANSPARENT_COLOR);
    eff[2] = drawReq[2] && (alienRGB   != TRANSPARENT_COLOR);
    eff[3] = drawReq[3] && (playerRGB  != TRANSPARENT_COLOR);
  end

  always_comb begin
    rgb_d = BG_RGB;
    sel_d = 3'd4;
    if (eff[0]) begin
      rgb_d = missileRGB;
      sel_d = 3'd0;
    end else if (eff[1]) begin
      rgb_d = bombRGB;
      sel_d = 3'd1;
    end else if (eff[2]) begin
      rgb_d = alienRGB;
      sel_d = 3'd2;
    end else if (eff[3]) begin
      rgb_d = playerRGB;
      sel_d = 3'd3;
    end
  end

  always_comb begin
    ovl[0] = eff[0] & eff[2];
    ovl[1] = eff[1] & eff[3];
    ovl[2] = eff[2] & boardersDrawReq;
    ovl[3] = eff[3] & boardersDrawReq;
  end

  // On a frame boundary the finished frame's flags move to snap_q for reporting,
  // while the boundary cycle's own overlaps seed the new frame's flags.
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    snap_d  = snap_q;
    pulse_d = '0;
    ovl_g   = collisionEn ? ovl : '0;
    case (state_q)
      WAIT_SOF: begin
        if (startOfFrame) state_d = COLLECT;
      end
      COLLECT: begin
        if (startOfFrame) begin
          state_d = REPORT;
          snap_d  = flags_q;
          flags_d = ovl_g;
        end else begin
          flags_d = flags_q | ovl_g;
        end
      end
      REPORT: begin
        pulse_d = snap_q;
        if (startOfFrame) begin
          state_d = REPORT;
          snap_d  = flags_q;
          flags_d = ovl_g;
        end else begin
          state_d = COLLECT;
          flags_d = flags_q | ovl_g;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= WAIT_SOF;
      rgb_q   <= '0;
      sel_q   <= 3'd4;
      flags_q <= '0;
      snap_q  <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      rgb_q   <= rgb_d;
      sel_q   <= sel_d;
      flags_q <= flags_d;
      snap_q  <= snap_d;
      pulse_q <= pulse_d;
    end
  end

  assign RGBOut         = rgb_q;
  assign layerSel       = sel_q;
  assign alienHit       = pulse_q[0];
  assign playerHit      = pulse_q[1];
  assign alienAtBorder  = pulse_q[2];
  assign playerAtBorder = pulse_q[3];

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Directed bench for draw_layer_arbiter: arbitration, transparency and frame-based collision pulses.
module tb_draw_layer_arbiter;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       collisionEn;
  logic [3:0] drawReq;
  logic [7:0] missileRGB, bombRGB, alienRGB, playerRGB, BG_RGB;
  logic       boardersDrawReq;
  logic [7:0] RGBOut;
  logic [2:0] layerSel;
  logic       alienHit, playerHit, alienAtBorder, playerAtBorder;

  int unsigned errors = 0;
  int unsigned checks = 0;

  draw_layer_arbiter #(.TRANSPARENT_COLOR(8'hFF)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .collisionEn    (collisionEn),
    .drawReq        (drawReq),
    .missileRGB     (missileRGB),
    .bombRGB        (bombRGB),
    .alienRGB       (alienRGB),
    .playerRGB      (playerRGB),
    .BG_RGB         (BG_RGB),
    .boardersDrawReq(boardersDrawReq),
    .RGBOut         (RGBOut),
    .layerSel       (layerSel),
    .alienHit       (alienHit),
    .playerHit      (playerHit),
    .alienAtBorder  (alienAtBorder),
    .playerAtBorder (playerAtBorder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pulses();
    return {4'b0, playerAtBorder, alienAtBorder, playerHit, alienHit};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arb(input string tag, input logic [3:0] req,
                     input logic [7:0] exp_rgb, input logic [2:0] exp_sel);
    drawReq = req;
    tick();
    check({tag, "_rgb"}, RGBOut, exp_rgb);
    check({tag, "_sel"}, {5'b0, layerSel}, {5'b0, exp_sel});
  endtask

  // Pulses SOF with whatever overlap the caller set up, then watches the report window.
  task automatic frame_end(input string tag, input logic [3:0] exp);
    startOfFrame = 1'b1;
    tick();
    startOfFrame    = 1'b0;
    drawReq         = 4'b0;
    boardersDrawReq = 1'b0;
    check({tag, "_pre"}, pulses(), 8'h00);
    tick();
    check({tag, "_rep"}, pulses(), {4'b0, exp});
    tick();
    check({tag, "_post"}, pulses(), 8'h00);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; collisionEn = 1'b1;
    drawReq = 4'b0; boardersDrawReq = 1'b0;
    missileRGB = 8'h11; bombRGB = 8'h22; alienRGB = 8'h33; playerRGB = 8'h44;
    BG_RGB = 8'h1C;
    tick(); tick();
    check("rst_rgb", RGBOut, 8'h00);
    check("rst_sel", {5'b0, layerSel}, 8'd4);
    check("rst_pulse", pulses(), 8'h00);
    resetN = 1'b1;
    tick();

    // Arbitration (also overlaps while waiting for the first SOF)
    arb("prio0", 4'b1111, 8'h11, 3'd0);
    arb("prio1", 4'b1110, 8'h22, 3'd1);
    arb("prio2", 4'b1100, 8'h33, 3'd2);
    arb("prio3", 4'b1000, 8'h44, 3'd3);
    arb("none",  4'b0000, 8'h1C, 3'd4);
    boardersDrawReq = 1'b1;
    arb("border_bg", 4'b1000, 8'h44, 3'd3);
    boardersDrawReq = 1'b0;
    missileRGB = 8'hFF;
    arb("transp", 4'b0001, 8'h1C, 3'd4);
    bombRGB = 8'hFF;
    arb("transp2", 4'b0111, 8'h33, 3'd2);
    missileRGB = 8'h11; bombRGB = 8'h22;
    drawReq = 4'b0;

    // First SOF leaves WAIT_SOF; pre-SOF overlaps must never appear
    frame_end("first_sof", 4'b0000);
    frame_end("no_early", 4'b0000);

    // Mid-frame missile/alien overlap
    drawReq = 4'b0101; tick(); drawReq = 4'b0; tick(); tick();
    frame_end("aH", 4'b0001);
    frame_end("aH_clear", 4'b0000);

    // Overlap on the SOF cycle belongs to the next frame
    drawReq = 4'b1000; boardersDrawReq = 1'b1;
    frame_end("pB_sof", 4'b0000);
    frame_end("pB_next", 4'b1000);

    // Two terms in one frame
    drawReq = 4'b0100; boardersDrawReq = 1'b1; tick();
    drawReq = 4'b1010; boardersDrawReq = 1'b0; tick();
    drawReq = 4'b0;
    frame_end("aB_pH", 4'b0110);

    // Collision recording disabled
    collisionEn = 1'b0;
    drawReq = 4'b1111; boardersDrawReq = 1'b1; tick();
    collisionEn = 1'b1; drawReq = 4'b0; boardersDrawReq = 1'b0;
    frame_end("en_off", 4'b0000);

    // Reset mid-frame with a flag set
    drawReq = 4'b1010; tick(); drawReq = 4'b0001; tick();
    resetN = 1'b0; #1;
    check("mid_rst_rgb", RGBOut, 8'h00);
    check("mid_rst_sel", {5'b0, layerSel}, 8'd4);
    check("mid_rst_pulse", pulses(), 8'h00);
    drawReq = 4'b0;
    tick();
    resetN = 1'b1;
    tick();
    frame_end("after_rst1", 4'b0000);
    frame_end("after_rst2", 4'b0000);

    // Back-to-back SOF with pH pending
    drawReq = 4'b1010; tick(); drawReq = 4'b0;
    startOfFrame = 1'b1; tick();
    check("b2b_e0", pulses(), 8'h00);
    tick();
    startOfFrame = 1'b0;
    check("b2b_rep1", pulses(), 8'h02);
    tick();
    check("b2b_rep2", pulses(), 8'h00);
    tick();
    check("b2b_post", pulses(), 8'h00);
    frame_end("b2b_after", 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
